// File: rtl/tlul_a_rr_arbiter.sv
// TL-UL A-channel round-robin arbiter for NUM_MASTERS masters onto one slave,
// with in-order D-channel response routing via a FIFO of granted master indices.
module tlul_a_rr_arbiter #(
    parameter int unsigned NUM_MASTERS     = 3,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SIZE_WIDTH      = 3,
    parameter int unsigned SRC_WIDTH       = 2,
    parameter int unsigned SINK_WIDTH      = 1,
    parameter int unsigned OPCODE_WIDTH    = 3,
    parameter int unsigned PARAM_WIDTH     = 3,
    localparam int unsigned MASK_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                                  clk_100,
    input  logic                                  reset_n,
    // master A sockets
    input  logic [NUM_MASTERS-1:0]                m_a_valid,
    output logic [NUM_MASTERS-1:0]                m_a_ready,
    input  logic [NUM_MASTERS*OPCODE_WIDTH-1:0]   m_a_opcode,
    input  logic [NUM_MASTERS*PARAM_WIDTH-1:0]    m_a_param,
    input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]     m_a_size,
    input  logic [NUM_MASTERS*SRC_WIDTH-1:0]      m_a_source,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_a_address,
    input  logic [NUM_MASTERS*MASK_WIDTH-1:0]     m_a_mask,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_a_data,
    // slave A socket
    output logic                                  s_a_valid,
    input  logic                                  s_a_ready,
    output logic [OPCODE_WIDTH-1:0]               s_a_opcode,
    output logic [PARAM_WIDTH-1:0]                s_a_param,
    output logic [SIZE_WIDTH-1:0]                 s_a_size,
    output logic [SRC_WIDTH-1:0]                  s_a_source,
    output logic [ADDR_WIDTH-1:0]                 s_a_address,
    output logic [MASK_WIDTH-1:0]                 s_a_mask,
    output logic [DATA_WIDTH-1:0]                 s_a_data,
    // slave D socket
    input  logic                                  s_d_valid,
    output logic                                  s_d_ready,
    input  logic [OPCODE_WIDTH-1:0]               s_d_opcode,
    input  logic [PARAM_WIDTH-1:0]                s_d_param,
    input  logic [SIZE_WIDTH-1:0]                 s_d_size,
    input  logic [SRC_WIDTH-1:0]                  s_d_source,
    input  logic [SINK_WIDTH-1:0]                 s_d_sink,
    input  logic [DATA_WIDTH-1:0]                 s_d_data,
    input  logic                                  s_d_error,
    // master D sockets
    output logic [NUM_MASTERS-1:0]                m_d_valid,
    input  logic [NUM_MASTERS-1:0]                m_d_ready,
    output logic [NUM_MASTERS*OPCODE_WIDTH-1:0]   m_d_opcode,
    output logic [NUM_MASTERS*PARAM_WIDTH-1:0]    m_d_param,
    output logic [NUM_MASTERS*SIZE_WIDTH-1:0]     m_d_size,
    output logic [NUM_MASTERS*SRC_WIDTH-1:0]      m_d_source,
    output logic [NUM_MASTERS*SINK_WIDTH-1:0]     m_d_sink,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_d_data,
    output logic [NUM_MASTERS-1:0]                m_d_error,
    output logic                                  unexpected_d
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               unexp_q, unexp_d;
    logic [IDX_W-1:0]   fifo_q [MAX_OUTSTANDING];

    logic [IDX_W-1:0]   gnt;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   head;
    logic               granted;
    logic               can_issue;
    logic               fifo_empty;
    logic               a_hs;
    logic               d_hs;

    assign can_issue  = (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];
    assign a_hs       = s_a_valid & s_a_ready;
    assign d_hs       = s_d_valid & s_d_ready;

    // State register
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (s_a_valid && !s_a_ready) begin
                    state_d = LOCKED;
                    gnt_d   = gnt;
                end
            end
            LOCKED: begin
                if (a_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: grant selection; reset_n gating keeps outputs low while in reset
    always_comb begin
        gnt     = '0;
        cand    = '0;
        granted = 1'b0;
        if (state_q == LOCKED) begin
            gnt     = gnt_q;
            granted = reset_n;
        end else if (can_issue && reset_n) begin
            for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
                cand = IDX_W'((32'(rr_q) + k) % NUM_MASTERS);
                if (!granted && m_a_valid[cand]) begin
                    gnt     = cand;
                    granted = 1'b1;
                end
            end
        end
    end

    assign s_a_valid   = granted & m_a_valid[gnt];
    assign m_a_ready   = (granted && s_a_ready) ? (ONE_HOT0 << gnt) : '0;
    assign s_a_opcode  = OPCODE_WIDTH'(m_a_opcode  >> (32'(gnt) * OPCODE_WIDTH));
    assign s_a_param   = PARAM_WIDTH'(m_a_param    >> (32'(gnt) * PARAM_WIDTH));
    assign s_a_size    = SIZE_WIDTH'(m_a_size      >> (32'(gnt) * SIZE_WIDTH));
    assign s_a_source  = SRC_WIDTH'(m_a_source     >> (32'(gnt) * SRC_WIDTH));
    assign s_a_address = ADDR_WIDTH'(m_a_address   >> (32'(gnt) * ADDR_WIDTH));
    assign s_a_mask    = MASK_WIDTH'(m_a_mask      >> (32'(gnt) * MASK_WIDTH));
    assign s_a_data    = DATA_WIDTH'(m_a_data      >> (32'(gnt) * DATA_WIDTH));

    // D routing: head of the route FIFO owns the current response
    assign m_d_valid   = (!fifo_empty && s_d_valid) ? (ONE_HOT0 << head) : '0;
    assign s_d_ready   = !fifo_empty && m_d_ready[head];
    assign m_d_opcode  = {NUM_MASTERS{s_d_opcode}};
    assign m_d_param   = {NUM_MASTERS{s_d_param}};
    assign m_d_size    = {NUM_MASTERS{s_d_size}};
    assign m_d_source  = {NUM_MASTERS{s_d_source}};
    assign m_d_sink    = {NUM_MASTERS{s_d_sink}};
    assign m_d_data    = {NUM_MASTERS{s_d_data}};
    assign m_d_error   = {NUM_MASTERS{s_d_error}};
    assign unexpected_d = unexp_q;

    always_comb begin
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        unexp_d  = s_d_valid & fifo_empty;
        if (a_hs) begin
            rr_d     = (gnt == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt + IDX_W'(1);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (d_hs) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({a_hs, d_hs})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            unexp_q  <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            unexp_q  <= unexp_d;
        end
    end

    // Entries are only read while count is non-zero, so storage needs no reset
    always_ff @(posedge clk_100) begin
        if (a_hs) fifo_q[wr_ptr_q] <= gnt;
    end

endmodule

// File: tb/tb_tlul_a_rr_arbiter.sv
// Directed self-checking bench for tlul_a_rr_arbiter (3 masters, 8 outstanding).
module tb_tlul_a_rr_arbiter;

    localparam int unsigned NM = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    logic               clk_100 = 1'b0;
    logic               reset_n;
    logic [NM-1:0]      m_a_valid;
    logic [NM-1:0]      m_a_ready;
    logic [NM*3-1:0]    m_a_opcode;
    logic [NM*3-1:0]    m_a_param;
    logic [NM*3-1:0]    m_a_size;
    logic [NM*2-1:0]    m_a_source;
    logic [NM*AW-1:0]   m_a_address;
    logic [NM*MW-1:0]   m_a_mask;
    logic [NM*DW-1:0]   m_a_data;
    logic               s_a_valid;
    logic               s_a_ready;
    logic [2:0]         s_a_opcode;
    logic [2:0]         s_a_param;
    logic [2:0]         s_a_size;
    logic [1:0]         s_a_source;
    logic [AW-1:0]      s_a_address;
    logic [MW-1:0]      s_a_mask;
    logic [DW-1:0]      s_a_data;
    logic               s_d_valid;
    logic               s_d_ready;
    logic [2:0]         s_d_opcode;
    logic [2:0]         s_d_param;
    logic [2:0]         s_d_size;
    logic [1:0]         s_d_source;
    logic [0:0]         s_d_sink;
    logic [DW-1:0]      s_d_data;
    logic               s_d_error;
    logic [NM-1:0]      m_d_valid;
    logic [NM-1:0]      m_d_ready;
    logic [NM*3-1:0]    m_d_opcode;
    logic [NM*3-1:0]    m_d_param;
    logic [NM*3-1:0]    m_d_size;
    logic [NM*2-1:0]    m_d_source;
    logic [NM-1:0]      m_d_sink;
    logic [NM*DW-1:0]   m_d_data;
    logic [NM-1:0]      m_d_error;
    logic               unexpected_d;

    int checks   = 0;
    int failures = 0;

    tlul_a_rr_arbiter #(
        .NUM_MASTERS     (3),
        .MAX_OUTSTANDING (8),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clk_100      (clk_100),
        .reset_n      (reset_n),
        .m_a_valid    (m_a_valid),
        .m_a_ready    (m_a_ready),
        .m_a_opcode   (m_a_opcode),
        .m_a_param    (m_a_param),
        .m_a_size     (m_a_size),
        .m_a_source   (m_a_source),
        .m_a_address  (m_a_address),
        .m_a_mask     (m_a_mask),
        .m_a_data     (m_a_data),
        .s_a_valid    (s_a_valid),
        .s_a_ready    (s_a_ready),
        .s_a_opcode   (s_a_opcode),
        .s_a_param    (s_a_param),
        .s_a_size     (s_a_size),
        .s_a_source   (s_a_source),
        .s_a_address  (s_a_address),
        .s_a_mask     (s_a_mask),
        .s_a_data     (s_a_data),
        .s_d_valid    (s_d_valid),
        .s_d_ready    (s_d_ready),
        .s_d_opcode   (s_d_opcode),
        .s_d_param    (s_d_param),
        .s_d_size     (s_d_size),
        .s_d_source   (s_d_source),
        .s_d_sink     (s_d_sink),
        .s_d_data     (s_d_data),
        .s_d_error    (s_d_error),
        .m_d_valid    (m_d_valid),
        .m_d_ready    (m_d_ready),
        .m_d_opcode   (m_d_opcode),
        .m_d_param    (m_d_param),
        .m_d_size     (m_d_size),
        .m_d_source   (m_d_source),
        .m_d_sink     (m_d_sink),
        .m_d_data     (m_d_data),
        .m_d_error    (m_d_error),
        .unexpected_d (unexpected_d)
    );

    always #5 clk_100 = ~clk_100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        m_a_valid  = '0;
        s_a_ready  = 1'b0;
        s_d_valid  = 1'b0;
        m_d_ready  = '0;
        s_d_opcode = 3'd1;
        s_d_param  = '0;
        s_d_size   = 3'd2;
        s_d_source = '0;
        s_d_sink   = '0;
        s_d_data   = '0;
        s_d_error  = 1'b0;
        for (int i = 0; i < NM; i++) begin
            m_a_opcode[i*3 +: 3]    = 3'd4;
            m_a_param[i*3 +: 3]     = '0;
            m_a_size[i*3 +: 3]      = 3'd2;
            m_a_source[i*2 +: 2]    = 2'(i);
            m_a_address[i*AW +: AW] = 32'h1000 * (i + 1);
            m_a_mask[i*MW +: MW]    = 4'hF;
            m_a_data[i*DW +: DW]    = 32'hA0 + i;
        end
        m_a_valid = 3'b111;
        s_d_valid = 1'b1;
        #12;
        chk("rst_s_a_valid", s_a_valid, 1'b0);
        chk("rst_m_a_ready", m_a_ready, 3'b000);
        chk("rst_s_d_ready", s_d_ready, 1'b0);
        chk("rst_m_d_valid", m_d_valid, 3'b000);
        chk("rst_unexp", unexpected_d, 1'b0);
        s_d_valid = 1'b0;
        reset_n   = 1'b1;
        tick();

        // 1: round-robin 0,1,2 then master 0 again
        s_a_ready = 1'b1;
        #1;
        chk("t1_rdy0", m_a_ready, 3'b001);
        chk("t1_addr0", s_a_address, 32'h1000);
        tick();
        chk("t1_rdy1", m_a_ready, 3'b010);
        chk("t1_addr1", s_a_address, 32'h2000);
        tick();
        chk("t1_rdy2", m_a_ready, 3'b100);
        chk("t1_src2", s_a_source, 2'd2);
        tick();
        m_a_valid = 3'b001;
        #1;
        chk("t1_rdy0b", m_a_ready, 3'b001);
        tick();
        m_a_valid = '0;
        s_d_valid = 1'b1;
        m_d_ready = 3'b111;
        #1;
        chk("t1_d0", m_d_valid, 3'b001);
        chk("t1_sdr", s_d_ready, 1'b1);
        tick();
        chk("t1_d1", m_d_valid, 3'b010);
        tick();
        chk("t1_d2", m_d_valid, 3'b100);
        tick();
        chk("t1_d3", m_d_valid, 3'b001);
        tick();
        s_d_valid = 1'b0;

        // 2: lock on master 1 while slave stalls; master 0 joins
        s_a_ready = 1'b0;
        m_a_valid = 3'b010;
        #1;
        chk("t2_sav", s_a_valid, 1'b1);
        chk("t2_addr_c1", s_a_address, 32'h2000);
        chk("t2_rdy_c1", m_a_ready, 3'b000);
        tick();
        m_a_valid = 3'b011;
        #1;
        chk("t2_addr_c2", s_a_address, 32'h2000);
        tick();
        chk("t2_addr_c3", s_a_address, 32'h2000);
        tick();
        s_a_ready = 1'b1;
        #1;
        chk("t2_rdy_hs", m_a_ready, 3'b010);
        chk("t2_addr_hs", s_a_address, 32'h2000);
        tick();
        m_a_valid = 3'b001;
        #1;
        chk("t2_next", m_a_ready, 3'b001);
        chk("t2_addr_next", s_a_address, 32'h1000);
        tick();
        m_a_valid = '0;
        s_d_valid = 1'b1;
        #1;
        chk("t2_d0", m_d_valid, 3'b010);
        tick();
        chk("t2_d1", m_d_valid, 3'b001);
        tick();
        s_d_valid = 1'b0;

        // 3: fill the route FIFO, 9th stalls until a pop
        m_a_valid = 3'b001;
        for (int n = 0; n < 8; n++) begin
            #1;
            chk("t3_fill", m_a_ready, 3'b001);
            tick();
        end
        #1;
        chk("t3_full_sav", s_a_valid, 1'b0);
        chk("t3_full_rdy", m_a_ready, 3'b000);
        s_d_valid = 1'b1;
        m_d_ready = 3'b001;
        #1;
        chk("t3_pop_mdv", m_d_valid, 3'b001);
        chk("t3_pop_sdr", s_d_ready, 1'b1);
        chk("t3_nobypass", s_a_valid, 1'b0);
        tick();
        s_d_valid = 1'b0;
        #1;
        chk("t3_9th_rdy", m_a_ready, 3'b001);
        chk("t3_9th_sav", s_a_valid, 1'b1);
        tick();
        m_a_valid = '0;
        s_d_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            #1;
            chk("t3_drain", m_d_valid, 3'b001);
            tick();
        end
        s_d_valid = 1'b0;
        #1;
        chk("t3_empty_sdr", s_d_ready, 1'b0);

        // 4: masters 2 then 0, responses routed in order with data
        m_a_valid = 3'b100;
        #1;
        chk("t4_g2", m_a_ready, 3'b100);
        tick();
        m_a_valid = 3'b001;
        #1;
        chk("t4_g0", m_a_ready, 3'b001);
        tick();
        m_a_valid = '0;
        m_d_ready = 3'b111;
        s_d_valid = 1'b1;
        s_d_data  = 32'hDEADBEEF;
        #1;
        chk("t4_mdv2", m_d_valid, 3'b100);
        chk("t4_data2", m_d_data[2*DW +: DW], 32'hDEADBEEF);
        tick();
        s_d_data = 32'hCAFEBABE;
        #1;
        chk("t4_mdv0", m_d_valid, 3'b001);
        chk("t4_data0", m_d_data[0 +: DW], 32'hCAFEBABE);
        tick();
        s_d_valid = 1'b0;

        // 5: D backpressure holds the FIFO; push+pop keeps count
        m_a_valid = 3'b010;
        #1;
        chk("t5_g1", m_a_ready, 3'b010);
        tick();
        m_a_valid = '0;
        m_d_ready = 3'b000;
        s_d_valid = 1'b1;
        #1;
        chk("t5_mdv", m_d_valid, 3'b010);
        chk("t5_sdr0", s_d_ready, 1'b0);
        tick();
        chk("t5_hold", m_d_valid, 3'b010);
        m_d_ready = 3'b010;
        m_a_valid = 3'b100;
        #1;
        chk("t5_sdr1", s_d_ready, 1'b1);
        chk("t5_push", m_a_ready, 3'b100);
        tick();
        m_a_valid = '0;
        #1;
        chk("t5_head", m_d_valid, 3'b100);
        chk("t5_sdr_after", s_d_ready, 1'b0);
        m_d_ready = 3'b100;
        tick();

        // 6: response with empty FIFO
        #1;
        chk("t6_mdv", m_d_valid, 3'b000);
        chk("t6_sdr", s_d_ready, 1'b0);
        chk("t6_pre", unexpected_d, 1'b0);
        tick();
        chk("t6_pulse", unexpected_d, 1'b1);
        s_d_valid = 1'b0;
        tick();
        chk("t6_end", unexpected_d, 1'b0);

        // 6b: asynchronous reset while locked on master 1
        m_a_valid = 3'b001;
        s_a_ready = 1'b1;
        tick();
        m_a_valid = 3'b010;
        s_a_ready = 1'b0;
        tick();
        chk("t6_locked", s_a_valid, 1'b1);
        s_d_valid = 1'b1;
        s_a_ready = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_sav", s_a_valid, 1'b0);
        chk("t6_rst_rdy", m_a_ready, 3'b000);
        chk("t6_rst_sdr", s_d_ready, 1'b0);
        chk("t6_rst_mdv", m_d_valid, 3'b000);
        s_d_valid = 1'b0;
        m_a_valid = 3'b011;
        #1;
        reset_n = 1'b1;
        #1;
        chk("t6_unlock", m_a_ready, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
